// File: rtl/checker_ctrl.sv
// checker_ctrl
// Command front-end for a checker core. Accepts one check command at a time
// over a valid/ready handshake, drives mode/start/address into the checker,
// captures the checker result byte on its end pulse, enforces a timeout and
// an abort, and returns the outcome over a valid/ready result handshake.
//
// Ports
//   sys_clk, sys_rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_mode[1:0], cmd_addr[63:0]    command payload
//   abort                            stop the current run (RUN only)
//   cmode, cstart, caddr             drive into the checker
//   cend, cctrl[7:0]                 checker done pulse and result byte
//   result_valid/result_ready        result handshake
//   result_ctrl, result_cycles,
//   result_timeout, result_aborted   result payload
//   busy                             high whenever not IDLE
//
// Parameters
//   TIMEOUT       maximum RUN cycles before a forced stop, 0 = no timeout
//   DRAIN_CYCLES  cycles cstart is held low after a run (2 or more)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a command, cmd_ready high
// ST_RUN    | cstart high, counting cycles until end, abort or timeout
// ST_DRAIN  | cstart low for DRAIN_CYCLES so the checker returns to idle
// ST_RESULT | result_valid high, waiting for result_ready

module checker_ctrl #(
   parameter logic [31:0] TIMEOUT      = 32'd1000000,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_mode,
   input  logic [63:0] cmd_addr,
   input  logic        abort,
   output logic [1:0]  cmode,
   output logic        cstart,
   output logic [63:0] caddr,
   input  logic        cend,
   input  logic [7:0]  cctrl,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [7:0]  result_ctrl,
   output logic [31:0] result_cycles,
   output logic        result_timeout,
   output logic        result_aborted,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   // Drain counter is loaded on leaving RUN and counts down to zero, so the
   // DRAIN state lasts exactly DRAIN_CYCLES cycles.
   localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

   state_t      state;
   logic [31:0] run_cnt;
   logic [31:0] drain_cnt;

   // Decoded straight from the state register so reset takes effect on
   // these without waiting for a clock edge.
   assign cmd_ready    = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign result_valid = (state == ST_RESULT);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state          <= ST_IDLE;
         cmode          <= 2'd0;
         caddr          <= 64'd0;
         cstart         <= 1'b0;
         run_cnt        <= 32'd0;
         drain_cnt      <= 32'd0;
         result_ctrl    <= 8'd0;
         result_cycles  <= 32'd0;
         result_timeout <= 1'b0;
         result_aborted <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmode          <= cmd_mode;
                  caddr          <= cmd_addr;
                  cstart         <= 1'b1;
                  run_cnt        <= 32'd0;
                  result_ctrl    <= 8'd0;
                  result_cycles  <= 32'd0;
                  result_timeout <= 1'b0;
                  result_aborted <= 1'b0;
                  state          <= ST_RUN;
               end
            end

            // Priority: checker end beats abort, abort beats timeout.
            ST_RUN: begin
               if (cend) begin
                  result_ctrl   <= cctrl;
                  result_cycles <= run_cnt;
                  cstart        <= 1'b0;
                  drain_cnt     <= DRAIN_LOAD;
                  state         <= ST_DRAIN;
               end else if (abort) begin
                  result_aborted <= 1'b1;
                  result_ctrl    <= 8'd0;
                  result_cycles  <= run_cnt;
                  cstart         <= 1'b0;
                  drain_cnt      <= DRAIN_LOAD;
                  state          <= ST_DRAIN;
               end else if ((TIMEOUT != 32'd0) && (run_cnt == TIMEOUT)) begin
                  result_timeout <= 1'b1;
                  result_ctrl    <= 8'd0;
                  result_cycles  <= TIMEOUT;
                  cstart         <= 1'b0;
                  drain_cnt      <= DRAIN_LOAD;
                  state          <= ST_DRAIN;
               end else if (run_cnt != 32'hFFFF_FFFF) begin
                  run_cnt <= run_cnt + 32'd1;
               end
            end

            // cend is deliberately not looked at here: a late or re-armed
            // pulse from the checker must not disturb the captured result.
            ST_DRAIN: begin
               if (drain_cnt == 32'd0) begin
                  state <= ST_RESULT;
               end else begin
                  drain_cnt <= drain_cnt - 32'd1;
               end
            end

            ST_RESULT: begin
               if (result_ready) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_checker_ctrl.sv
module tb_checker_ctrl;

   logic        sys_clk;
   logic        sys_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [63:0] cmd_addr;
   logic        abort;
   logic [1:0]  cmode;
   logic        cstart;
   logic [63:0] caddr;
   logic        cend;
   logic [7:0]  cctrl;
   logic        result_valid;
   logic        result_ready;
   logic [7:0]  result_ctrl;
   logic [31:0] result_cycles;
   logic        result_timeout;
   logic        result_aborted;
   logic        busy;

   int checks = 0;
   int errors = 0;

   checker_ctrl #(
      .TIMEOUT      (32'd20),
      .DRAIN_CYCLES (2)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_mode       (cmd_mode),
      .cmd_addr       (cmd_addr),
      .abort          (abort),
      .cmode          (cmode),
      .cstart         (cstart),
      .caddr          (caddr),
      .cend           (cend),
      .cctrl          (cctrl),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_ctrl    (result_ctrl),
      .result_cycles  (result_cycles),
      .result_timeout (result_timeout),
      .result_aborted (result_aborted),
      .busy           (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge sys_clk);
   endtask

   // Offer a command at a negedge while IDLE; returns at the negedge right
   // after the accepting edge E.
   task automatic send_cmd(input logic [1:0] m, input logic [63:0] a);
      cmd_mode  = m;
      cmd_addr  = a;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (result_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: result_valid never rose within 20 cycles", name);
      end
   endtask

   task automatic take_result();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || cstart !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b busy=%b cstart=%b rv=%b want 1 0 0 0",
                  cmd_ready, busy, cstart, result_valid);
      end
      checks++;
      if (cmode !== 2'd0 || caddr !== 64'd0 || result_ctrl !== 8'd0 || result_cycles !== 32'd0 ||
          result_timeout !== 1'b0 || result_aborted !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: cmode=%0d caddr=%0h ctrl=%0h cyc=%0d to=%b ab=%b want all 0",
                  cmode, caddr, result_ctrl, result_cycles, result_timeout, result_aborted);
      end
      sys_rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int bad;
      send_cmd(2'd2, 64'd5);
      checks++;
      if (cstart !== 1'b1 || cmode !== 2'd2 || caddr !== 64'd5 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept: cstart=%b cmode=%0d caddr=%0h busy=%b ready=%b want 1 2 5 1 0",
                  cstart, cmode, caddr, busy, cmd_ready);
      end
      bad = 0;
      for (int j = 1; j <= 7; j++) begin
         tick();
         if (cstart !== 1'b1) bad++;
      end
      cend  = 1'b1;
      cctrl = 8'h05;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      checks++;
      if (bad != 0 || cstart !== 1'b0) begin
         errors++;
         $display("FAIL basic_cstart: low_during_run=%0d cstart_at_E8=%b want 0 0", bad, cstart);
      end
      tick();
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_valid_early: result_valid=%b at E+9 want 0", result_valid);
      end
      tick();
      checks++;
      if (result_valid !== 1'b1 || result_ctrl !== 8'h05 || result_cycles !== 32'd7 ||
          result_timeout !== 1'b0 || result_aborted !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: rv=%b ctrl=%0h cyc=%0d to=%b ab=%b want 1 05 7 0 0",
                  result_valid, result_ctrl, result_cycles, result_timeout, result_aborted);
      end
      take_result();
      checks++;
      if (result_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || cmode !== 2'd2 || caddr !== 64'd5) begin
         errors++;
         $display("FAIL basic_release: rv=%b ready=%b busy=%b cmode=%0d caddr=%0h want 0 1 0 2 5",
                  result_valid, cmd_ready, busy, cmode, caddr);
      end
   endtask

   task automatic test_timeout();
      int hi;
      int guard;
      send_cmd(2'd1, 64'h1234);
      hi = 0;
      guard = 0;
      while (cstart === 1'b1 && guard < 100) begin
         hi++;
         tick();
         guard++;
      end
      checks++;
      if (hi != 21) begin
         errors++;
         $display("FAIL timeout_len: cstart high %0d cycles want 21", hi);
      end
      wait_valid("timeout_wait");
      checks++;
      if (result_ctrl !== 8'h00 || result_cycles !== 32'd20 || result_timeout !== 1'b1 || result_aborted !== 1'b0) begin
         errors++;
         $display("FAIL timeout_result: ctrl=%0h cyc=%0d to=%b ab=%b want 00 20 1 0",
                  result_ctrl, result_cycles, result_timeout, result_aborted);
      end
      take_result();
   endtask

   task automatic test_abort();
      // cend and abort together: cend wins
      send_cmd(2'd3, 64'hA);
      ticks(3);
      abort = 1'b1;
      cend  = 1'b1;
      cctrl = 8'hA5;
      tick();
      abort = 1'b0;
      cend  = 1'b0;
      cctrl = 8'h00;
      wait_valid("abort_end_wait");
      checks++;
      if (result_ctrl !== 8'hA5 || result_aborted !== 1'b0 || result_timeout !== 1'b0 || result_cycles !== 32'd3) begin
         errors++;
         $display("FAIL abort_vs_end: ctrl=%0h ab=%b to=%b cyc=%0d want a5 0 0 3",
                  result_ctrl, result_aborted, result_timeout, result_cycles);
      end
      take_result();

      // abort alone
      send_cmd(2'd0, 64'hB);
      ticks(4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (cstart !== 1'b0) begin
         errors++;
         $display("FAIL abort_cstart: cstart=%b after abort want 0", cstart);
      end
      wait_valid("abort_wait");
      checks++;
      if (result_ctrl !== 8'h00 || result_aborted !== 1'b1 || result_timeout !== 1'b0 || result_cycles !== 32'd4) begin
         errors++;
         $display("FAIL abort_alone: ctrl=%0h ab=%b to=%b cyc=%0d want 00 1 0 4",
                  result_ctrl, result_aborted, result_timeout, result_cycles);
      end
      take_result();

      // abort and timeout in the same cycle: abort wins
      send_cmd(2'd1, 64'hC);
      ticks(20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_valid("abort_to_wait");
      checks++;
      if (result_aborted !== 1'b1 || result_timeout !== 1'b0 || result_cycles !== 32'd20 || result_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL abort_vs_timeout: ab=%b to=%b cyc=%0d ctrl=%0h want 1 0 20 00",
                  result_aborted, result_timeout, result_cycles, result_ctrl);
      end
      take_result();

      // cend and timeout in the same cycle: cend wins
      send_cmd(2'd1, 64'hD);
      ticks(20);
      cend  = 1'b1;
      cctrl = 8'h3C;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      wait_valid("end_to_wait");
      checks++;
      if (result_ctrl !== 8'h3C || result_timeout !== 1'b0 || result_aborted !== 1'b0 || result_cycles !== 32'd20) begin
         errors++;
         $display("FAIL end_vs_timeout: ctrl=%0h to=%b ab=%b cyc=%0d want 3c 0 0 20",
                  result_ctrl, result_timeout, result_aborted, result_cycles);
      end
      take_result();

      // abort outside RUN does nothing
      abort = 1'b1;
      ticks(2);
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b ready=%b rv=%b want 0 1 0", busy, cmd_ready, result_valid);
      end
      abort = 1'b0;
   endtask

   task automatic test_backpressure();
      int bad;
      send_cmd(2'd2, 64'h77);
      ticks(2);
      cend  = 1'b1;
      cctrl = 8'h11;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      wait_valid("bp_wait");
      cmd_mode  = 2'd1;
      cmd_addr  = 64'hDEAD_BEEF_0000_0001;
      cmd_valid = 1'b1;
      bad = 0;
      for (int j = 0; j < 10; j++) begin
         if (result_valid !== 1'b1 || result_ctrl !== 8'h11 || result_cycles !== 32'd2 ||
             cmd_ready !== 1'b0 || cstart !== 1'b0 || cmode !== 2'd2) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_stable: %0d of 10 cycles unstable or accepted early want 0", bad);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      checks++;
      if (cstart !== 1'b0 || cmode !== 2'd2 || cmd_ready !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: cstart=%b cmode=%0d ready=%b rv=%b want 0 2 1 0",
                  cstart, cmode, cmd_ready, result_valid);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (cstart !== 1'b1 || cmode !== 2'd1 || caddr !== 64'hDEAD_BEEF_0000_0001) begin
         errors++;
         $display("FAIL bp_second_accept: cstart=%b cmode=%0d caddr=%0h want 1 1 deadbeef00000001",
                  cstart, cmode, caddr);
      end
      cend  = 1'b1;
      cctrl = 8'h22;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      wait_valid("bp_second_wait");
      checks++;
      if (result_ctrl !== 8'h22 || result_cycles !== 32'd0) begin
         errors++;
         $display("FAIL bp_second_result: ctrl=%0h cyc=%0d want 22 0", result_ctrl, result_cycles);
      end
      take_result();
   endtask

   task automatic test_reset_mid_run();
      int bad;
      send_cmd(2'd3, 64'hFEED);
      ticks(3);
      #2;
      sys_rst = 1'b1;
      #1;
      checks++;
      if (cstart !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || result_valid !== 1'b0 ||
          caddr !== 64'd0 || cmode !== 2'd0) begin
         errors++;
         $display("FAIL rst_async: cstart=%b busy=%b ready=%b rv=%b caddr=%0h cmode=%0d want 0 0 1 0 0 0",
                  cstart, busy, cmd_ready, result_valid, caddr, cmode);
      end
      tick();
      sys_rst = 1'b0;
      bad = 0;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_no_result: %0d cycles with result_valid or busy want 0", bad);
      end
      send_cmd(2'd1, 64'h99);
      tick();
      cend  = 1'b1;
      cctrl = 8'h77;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      ticks(2);
      checks++;
      if (result_valid !== 1'b1 || result_ctrl !== 8'h77 || result_cycles !== 32'd1 || result_aborted !== 1'b0) begin
         errors++;
         $display("FAIL rst_next_run: rv=%b ctrl=%0h cyc=%0d ab=%b want 1 77 1 0",
                  result_valid, result_ctrl, result_cycles, result_aborted);
      end
      take_result();
   endtask

   task automatic test_drain_stray();
      int lo;
      send_cmd(2'd0, 64'h42);
      ticks(4);
      cend  = 1'b1;
      cctrl = 8'h42;
      tick();
      lo = 0;
      cend  = 1'b1;
      cctrl = 8'h99;
      if (cstart === 1'b0 && result_valid === 1'b0) lo++;
      tick();
      cend  = 1'b0;
      cctrl = 8'h00;
      if (cstart === 1'b0 && result_valid === 1'b0) lo++;
      tick();
      checks++;
      if (lo != 2 || result_valid !== 1'b1 || cstart !== 1'b0) begin
         errors++;
         $display("FAIL drain_len: drain cycles=%0d rv=%b cstart=%b want 2 1 0", lo, result_valid, cstart);
      end
      checks++;
      if (result_ctrl !== 8'h42 || result_cycles !== 32'd4 || result_timeout !== 1'b0 || result_aborted !== 1'b0) begin
         errors++;
         $display("FAIL drain_stray: ctrl=%0h cyc=%0d to=%b ab=%b want 42 4 0 0",
                  result_ctrl, result_cycles, result_timeout, result_aborted);
      end
      take_result();
   endtask

   task automatic test_back_to_back();
      int t;
      int rises [$];
      logic prev;
      cmd_mode     = 2'd2;
      cmd_addr     = 64'h5;
      cmd_valid    = 1'b1;
      result_ready = 1'b1;
      prev = 1'b0;
      for (t = 0; t < 20; t++) begin
         tick();
         if (cstart === 1'b1 && prev !== 1'b1) rises.push_back(t);
         prev = cstart;
         cend = cstart;
      end
      cmd_valid = 1'b0;
      t = 0;
      while ((busy !== 1'b0 || cstart !== 1'b0) && t < 20) begin
         tick();
         cend = cstart;
         t++;
      end
      cend = 1'b0;
      result_ready = 1'b0;
      tick();
      checks++;
      if (rises.size() < 3) begin
         errors++;
         $display("FAIL b2b_count: %0d accepts in 20 cycles want at least 3", rises.size());
      end else if (rises[1] - rises[0] != 5 || rises[2] - rises[1] != 5) begin
         errors++;
         $display("FAIL b2b_period: periods %0d %0d want 5 5", rises[1] - rises[0], rises[2] - rises[1]);
      end
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b ready=%b want 0 1", busy, cmd_ready);
      end
   endtask

   initial begin
      sys_rst      = 1'b1;
      cmd_valid    = 1'b0;
      cmd_mode     = 2'd0;
      cmd_addr     = 64'd0;
      abort        = 1'b0;
      cend         = 1'b0;
      cctrl        = 8'd0;
      result_ready = 1'b0;
      test_reset();
      test_basic();
      test_timeout();
      test_abort();
      test_backpressure();
      test_reset_mid_run();
      test_drain_stray();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/checker_ctrl.md
# checker_ctrl

Command front-end for the checker cores. It sits directly upstream of a checker (mode, start, address in; end pulse and control byte out). It accepts one check command at a time over a valid/ready handshake and drives `cmode`/`cstart`/`caddr` into the checker. It captures the checker's `cctrl` result, enforces a timeout and an abort, and returns the outcome over a valid/ready result handshake.

## Interface
- `TIMEOUT`, default 32'd1000000: maximum RUN cycles before forced stop; 0 disables the timeout.
- `DRAIN_CYCLES`, default 2: cycles `cstart` is held low after a run, so the checker returns to idle. Minimum 2.

- `sys_clk`  in  1  system clock; everything is on its rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_mode`  in  2  checker mode for this command.
- `cmd_addr`  in  64  checker address/argument.
- `abort`  in  1  stop the current run; sampled in RUN only.
- `cmode`  out  2  mode to the checker.
- `cstart`  out  1  start/hold to the checker.
- `caddr`  out  64  address to the checker.
- `cend`  in  1  checker done; treated as a single-cycle pulse.
- `cctrl`  in  8  checker result; valid only while `cend` is high.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `result_ctrl`  out  8  captured `cctrl`; 0 on timeout or abort.
- `result_cycles`  out  32  RUN cycles counted before completion.
- `result_timeout`  out  1  run ended by timeout.
- `result_aborted`  out  1  run ended by `abort`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, RESULT.
- `cmd_ready` = (state == IDLE). It is combinational, so it is 1 during and after reset.
- **IDLE**
  - On `cmd_valid & cmd_ready`: register `cmode<=cmd_mode`, `caddr<=cmd_addr`, `cstart<=1`.
  - Clear `run_cnt` and all `result_*` flags/data.
  - Go to RUN.
- **RUN**, evaluated in priority order each edge:
  - `cend=1`: `result_ctrl<=cctrl`, `result_cycles<=run_cnt`, `cstart<=0`, go to DRAIN.
  - `abort=1`: `result_aborted<=1`, `result_ctrl<=0`, `result_cycles<=run_cnt`, `cstart<=0`, go to DRAIN.
  - `TIMEOUT!=0` and `run_cnt==TIMEOUT`: `result_timeout<=1`, `result_ctrl<=0`, `result_cycles<=TIMEOUT`, `cstart<=0`, go to DRAIN.
  - Otherwise: `run_cnt<=run_cnt+1`.
  - `run_cnt` is 32-bit and saturates at 32'hFFFFFFFF; it never wraps.
- **DRAIN**
  - `cstart` stays 0 for exactly `DRAIN_CYCLES` cycles, counted by a drain counter, then go to RESULT.
  - `cend` pulses seen here are ignored. The checker may re-arm for one cycle because `cstart` is registered; that is harmless.
- **RESULT**
  - `result_valid=1`; `result_*` are stable.
  - On `result_ready`, go to IDLE; `result_valid` drops the next cycle.
- `cmode`/`caddr` hold their last command value until the next accept.
- Reset (asynchronous, any state including mid-run):
  - State goes to IDLE.
  - `cstart`, `cmode`, `caddr`, `run_cnt` and all `result_*` go to 0.
  - `result_valid` goes to 0, `busy` goes to 0.

## Timing
- Accept at edge E: `cstart` is high from E. At most one command is in flight; back-to-back commands are separated by DRAIN plus RESULT.
- If the checker drives `cend` in the cycle after edge E+K:
  - `result_cycles`=K.
  - `cstart` falls at edge E+K+1.
  - `result_valid` rises at edge E+K+1+`DRAIN_CYCLES`.
- Minimum command-to-command period: 1 (RUN) + `DRAIN_CYCLES` + 1 (RESULT with `result_ready` tied high) + 1 (IDLE) cycles.
- Simultaneous events in RUN:
  - `cend` and `abort` together: `cend` wins, `result_aborted`=0.
  - `cend` and timeout together: `cend` wins.
  - `abort` and timeout together: abort wins.
- `abort` outside RUN has no effect. `cmd_valid` outside IDLE is not accepted and must be held by the sender.

## Test plan
- Basic run: accept mode=2, addr=5 at E; model pulses `cend` with `cctrl`=8'h05 after E+7. Required: `cmode`=2 and `caddr`=5 from E, `cstart` falls at E+8, result is {ctrl=5, cycles=7, timeout=0, aborted=0}, `result_valid` rises at E+10.
- Timeout: TIMEOUT=20, model never pulses `cend`. Required: `cstart` is high for 21 cycles, result is {ctrl=0, cycles=20, timeout=1}.
- Abort versus end: pulse `abort` and `cend` (`cctrl`=8'hA5) in the same RUN cycle. Required: ctrl=A5, aborted=0. Repeat with `abort` alone: aborted=1, ctrl=0.
- Backpressure: hold `result_ready`=0 for 10 cycles while offering a second command. Required: `result_*` stable, `cmd_ready`=0, second command accepted only one cycle after `result_ready` rises.
- Reset mid-run: assert `sys_rst` asynchronously (between clock edges) 3 cycles into RUN. Required: `cstart`=0, `busy`=0 and `cmd_ready`=1 immediately with no clock edge; no `result_valid`; the next command runs normally.
- Drain spacing: a stray `cend` pulse during DRAIN. Required: ignored, result unchanged, `cstart` low for exactly `DRAIN_CYCLES` cycles.
